// File: rtl/sorter_pkg.sv
// Shared types for the sorter result streamer: the sorter output bundle,
// the buffered result entry, the streaming FSM states and the channel decode.
package sorter_pkg;

   localparam int SORTER_DATAWIDTH      = 8;
   localparam int SORTER_MAX_DATALENGTH = 32;

   typedef struct packed {
      logic [SORTER_MAX_DATALENGTH-1:0][SORTER_DATAWIDTH-1:0] data;
      logic [2:0]                                             channel;
   } sorter_top_io_t;

   typedef struct packed {
      logic [SORTER_MAX_DATALENGTH-1:0][SORTER_DATAWIDTH-1:0] data;
      logic [5:0]                                             k;
      logic [5:0]                                             length;
   } result_entry_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Channel 0 never reaches here; the wide channels all mean a full array.
   function automatic logic [5:0] chan_to_len(input logic [2:0] channel);
      logic [5:0] len;
      len = 6'd32;
      case (channel)
         3'd1:    len = 6'd4;
         3'd2:    len = 6'd8;
         3'd3:    len = 6'd16;
         default: len = 6'd32;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO of complete sorter results; a push into a full FIFO is only
// taken when the head is popped in the same cycle.
module result_fifo2
   import sorter_pkg::*;
(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          push,
   input  result_entry_t push_entry,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output result_entry_t head
);

   result_entry_t slot [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = slot[rd_ptr];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk_i) begin
      if (push_ok) slot[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/sorter_result_streamer.sv
// Streams the first k elements of each captured sorter result over a
// valid/ready handshake, buffering up to two results.
module sorter_result_streamer
   import sorter_pkg::*;
#(
   parameter int DATAWIDTH      = SORTER_DATAWIDTH,
   parameter int MAX_DATALENGTH = SORTER_MAX_DATALENGTH
)(
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  sorter_top_io_t       y_i,
   input  logic [5:0]           k_i,
   output logic [DATAWIDTH-1:0] data_o,
   output logic [4:0]           idx_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 last_o,
   output logic                 busy_o,
   output logic                 overflow_o
);

   localparam logic [5:0] MAX_LEN = 6'(MAX_DATALENGTH);

   state_t        state;
   state_t        state_next;
   logic [4:0]    idx;
   logic [4:0]    idx_next;
   logic          overflow_q;
   logic [5:0]    cap_len;
   logic [5:0]    cap_k;
   logic          capture;
   result_entry_t cap_entry;
   result_entry_t head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [5:0]    end_k;
   logic          fire;
   logic          at_last;
   logic          pop;

   // Decode and clamp the arriving result; a zero effective k is discarded.
   always_comb begin
      cap_len = chan_to_len(y_i.channel);
      if (cap_len > MAX_LEN) cap_len = MAX_LEN;
      cap_k = (k_i < cap_len) ? k_i : cap_len;
      capture = (y_i.channel != 3'd0) && (cap_k != 6'd0);
      cap_entry.data   = y_i.data;
      cap_entry.k      = cap_k;
      cap_entry.length = cap_len;
   end

   result_fifo2 u_fifo (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .push       (capture),
      .push_entry (cap_entry),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head)
   );

   assign end_k   = (head.k < head.length) ? head.k : head.length;
   assign valid_o = (state == STREAM);
   assign fire    = valid_o && ready_i;
   assign at_last = valid_o && ({1'b0, idx} == (end_k - 6'd1));
   assign pop     = fire && at_last;

   assign data_o     = valid_o ? DATAWIDTH'(head.data[idx]) : '0;
   assign idx_o      = valid_o ? idx : 5'd0;
   assign last_o     = at_last;
   assign busy_o     = !fifo_empty;
   assign overflow_o = overflow_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         idx        <= 5'd0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         overflow_q <= capture && fifo_full && !pop;
      end
   end

   // After the last beat, another entry remains if the FIFO was full or a
   // result is being accepted in the same cycle.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         IDLE: begin
            idx_next = 5'd0;
            if (capture) state_next = STREAM;
         end
         STREAM: begin
            if (fire) begin
               if (at_last) begin
                  idx_next   = 5'd0;
                  state_next = (fifo_full || capture) ? STREAM : IDLE;
               end else begin
                  idx_next = idx + 5'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = 5'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_sorter_result_streamer.sv
// Directed bench for sorter_result_streamer: hand-computed beats for clamping,
// back-pressure, overflow, same-cycle refill and mid-stream reset.
module tb_sorter_result_streamer;
   import sorter_pkg::*;

   logic           clk_i = 1'b0;
   logic           rstn_i;
   sorter_top_io_t y_i;
   logic [5:0]     k_i;
   logic [7:0]     data_o;
   logic [4:0]     idx_o;
   logic           valid_o;
   logic           ready_i;
   logic           last_o;
   logic           busy_o;
   logic           overflow_o;

   int total = 0;
   int bad   = 0;

   sorter_result_streamer dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .y_i        (y_i),
      .k_i        (k_i),
      .data_o     (data_o),
      .idx_o      (idx_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .last_o     (last_o),
      .busy_o     (busy_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] chan, input logic [5:0] k, input logic [7:0] base);
      y_i.channel = chan;
      k_i = k;
      for (int i = 0; i < 32; i++) y_i.data[i] = base + 8'(i);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkBeat(input string tag, input logic [4:0] idx, input logic [7:0] data, input logic last);
      checkOutput({tag, " valid"}, 32'(valid_o), 32'd1);
      checkOutput({tag, " idx"}, 32'(idx_o), 32'(idx));
      checkOutput({tag, " data"}, 32'(data_o), 32'(data));
      checkOutput({tag, " last"}, 32'(last_o), 32'(last));
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " valid"}, 32'(valid_o), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic [7:0] exp_data [6];
      logic [4:0] exp_idx  [6];

      rstn_i  = 1'b0;
      ready_i = 1'b1;
      applyStimulus(3'd0, 6'd0, 8'h00);
      tick();
      tick();
      checkOutput("rst valid", 32'(valid_o), 32'd0);
      checkOutput("rst last", 32'(last_o), 32'd0);
      checkOutput("rst busy", 32'(busy_o), 32'd0);
      checkOutput("rst overflow", 32'(overflow_o), 32'd0);
      checkOutput("rst data", 32'(data_o), 32'd0);
      checkOutput("rst idx", 32'(idx_o), 32'd0);
      rstn_i = 1'b1;
      tick();
      checkIdle("post rst");

      $display("[TB] channel 2, k 3");
      applyStimulus(3'd2, 6'd3, 8'h00);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkBeat("c2k3 b0", 5'd0, 8'h00, 1'b0);
      tick();
      checkBeat("c2k3 b1", 5'd1, 8'h01, 1'b0);
      tick();
      checkBeat("c2k3 b2", 5'd2, 8'h02, 1'b1);
      tick();
      checkIdle("c2k3 end");

      $display("[TB] channel 1, k 10 clamps to 4");
      applyStimulus(3'd1, 6'd10, 8'h10);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         checkBeat("c1k10", 5'(i), 8'h10 + 8'(i), i == 3);
         tick();
      end
      checkIdle("c1k10 end");

      $display("[TB] discard k 0");
      applyStimulus(3'd1, 6'd0, 8'h00);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkIdle("k0");
      checkOutput("k0 overflow", 32'(overflow_o), 32'd0);

      $display("[TB] back-pressure at idx 1");
      applyStimulus(3'd2, 6'd4, 8'h20);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkBeat("bp b0", 5'd0, 8'h20, 1'b0);
      tick();
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkBeat("bp hold", 5'd1, 8'h21, 1'b0);
      end
      ready_i = 1'b1;
      tick();
      checkBeat("bp b2", 5'd2, 8'h22, 1'b0);
      tick();
      checkBeat("bp b3", 5'd3, 8'h23, 1'b1);
      tick();
      checkIdle("bp end");

      $display("[TB] three results with ready low");
      ready_i = 1'b0;
      applyStimulus(3'd1, 6'd4, 8'h40);
      tick();
      applyStimulus(3'd1, 6'd2, 8'h50);
      tick();
      checkOutput("ovf after B", 32'(overflow_o), 32'd0);
      applyStimulus(3'd1, 6'd4, 8'h60);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkOutput("ovf pulse", 32'(overflow_o), 32'd1);
      tick();
      checkOutput("ovf cleared", 32'(overflow_o), 32'd0);
      checkOutput("ovf busy", 32'(busy_o), 32'd1);
      ready_i = 1'b1;
      exp_data = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51};
      exp_idx  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1};
      for (int i = 0; i < 6; i++) begin
         checkBeat("b2b", exp_idx[i], exp_data[i], (i == 3) || (i == 5));
         tick();
      end
      checkIdle("b2b end");

      $display("[TB] full FIFO refilled on last transfer");
      ready_i = 1'b0;
      applyStimulus(3'd1, 6'd2, 8'h70);
      tick();
      applyStimulus(3'd1, 6'd1, 8'h80);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      ready_i = 1'b1;
      checkBeat("refill A0", 5'd0, 8'h70, 1'b0);
      tick();
      checkBeat("refill A1", 5'd1, 8'h71, 1'b1);
      applyStimulus(3'd1, 6'd2, 8'h90);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkOutput("refill overflow", 32'(overflow_o), 32'd0);
      checkBeat("refill B0", 5'd0, 8'h80, 1'b1);
      tick();
      checkBeat("refill C0", 5'd0, 8'h90, 1'b0);
      tick();
      checkBeat("refill C1", 5'd1, 8'h91, 1'b1);
      tick();
      checkIdle("refill end");

      $display("[TB] wide channel clamps k 20 of 32");
      applyStimulus(3'd5, 6'd20, 8'hB0);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      repeat (18) tick();
      checkBeat("wide b18", 5'd18, 8'hC2, 1'b0);
      tick();
      checkBeat("wide b19", 5'd19, 8'hC3, 1'b1);
      tick();
      checkIdle("wide end");

      $display("[TB] reset mid-stream");
      applyStimulus(3'd3, 6'd16, 8'hA0);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      repeat (5) tick();
      checkBeat("mid b5", 5'd5, 8'hA5, 1'b0);
      #2;
      rstn_i = 1'b0;
      #1;
      checkIdle("mid rst");
      checkOutput("mid rst data", 32'(data_o), 32'd0);
      checkOutput("mid rst idx", 32'(idx_o), 32'd0);
      checkOutput("mid rst last", 32'(last_o), 32'd0);
      tick();
      rstn_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkIdle("after rst");
      end
      applyStimulus(3'd1, 6'd1, 8'hC0);
      tick();
      applyStimulus(3'd0, 6'd0, 8'h00);
      checkBeat("new after rst", 5'd0, 8'hC0, 1'b1);
      tick();
      checkIdle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
